// File: rtl/floating_div.sv
// floating_div: iterative IEEE-754 single-precision divider, restoring radix-2 mantissa divide, fixed 26-cycle start-to-done latency.
module floating_div #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out,
  output logic        done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, DIV, PACK} state_t;
  state_t r_state, w_next;
  logic [4:0]  r_cnt;
  logic [25:0] r_rem;
  logic [23:0] r_div;
  logic [24:0] r_q;
  logic signed [9:0] r_exp;
  logic        r_sign, r_spec;
  logic [31:0] r_spec_val;
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;
  logic        w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_adj, w_s;
  logic        w_nan, w_inf, w_zero;
  logic [31:0] w_spec_val, w_res;
  logic [9:0]  w_exp;
  logic [25:0] w_diff;
  logic        w_inc;
  logic [24:0] w_mr;
  logic signed [9:0] w_ef;
  assign busy = r_state != IDLE;
  always_comb begin
    w_ea   = A[30:23];
    w_eb   = B[30:23];
    w_ma   = {1'b1, A[22:0]};
    w_mb   = {1'b1, B[22:0]};
    w_za   = w_ea == 8'h00;
    w_zb   = w_eb == 8'h00;
    w_ia   = w_ea == 8'hFF && A[22:0] == 23'b0;
    w_ib   = w_eb == 8'hFF && B[22:0] == 23'b0;
    w_na   = w_ea == 8'hFF && A[22:0] != 23'b0;
    w_nb   = w_eb == 8'hFF && B[22:0] != 23'b0;
    w_s    = A[31] ^ B[31];
    w_adj  = w_ma < w_mb;
    w_exp  = {2'b0, w_ea} - {2'b0, w_eb} + 10'd127 - {9'b0, w_adj};
    w_nan  = w_na | w_nb | (w_za & w_zb) | (w_ia & w_ib);
    w_inf  = w_zb | w_ia;
    w_zero = w_za | w_ib;
    w_spec_val = w_nan ? QNAN : w_inf ? {w_s, 8'hFF, 23'b0} : {w_s, 31'b0};
  end
  // PACK: round-to-nearest-even on guard bit r_q[0] with remainder as sticky
  always_comb begin
    w_diff = r_rem - {2'b0, r_div};
    w_inc  = r_q[0] & ((r_rem != 26'b0) | r_q[1]);
    w_mr   = {1'b0, r_q[24:1]} + {24'b0, w_inc};
    w_ef   = r_exp + {9'b0, w_mr[24]};
    w_res  = r_spec ? r_spec_val :
             (w_ef >= 10'sd255) ? {r_sign, 8'hFF, 23'b0} :
             (w_ef <= 10'sd0) ? {r_sign, 31'b0} :
             {r_sign, w_ef[7:0], w_mr[22:0]};
  end
  always_comb begin
    w_next = r_state == IDLE ? (start ? DIV : IDLE) :
             r_state == DIV  ? (r_cnt == 5'd24 ? PACK : DIV) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out        <= 32'b0;
      done       <= 1'b0;
      r_cnt      <= 5'b0;
      r_rem      <= 26'b0;
      r_div      <= 24'b0;
      r_q        <= 25'b0;
      r_exp      <= 10'sd0;
      r_sign     <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_val <= 32'b0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE && start) begin
        r_sign     <= w_s;
        r_spec     <= w_nan | w_inf | w_zero;
        r_spec_val <= w_spec_val;
        r_exp      <= w_exp;
        r_rem      <= w_adj ? {1'b0, w_ma, 1'b0} : {2'b0, w_ma};
        r_div      <= w_mb;
        r_q        <= 25'b0;
        r_cnt      <= 5'b0;
      end else if (r_state == DIV) begin
        r_rem <= w_diff[25] ? {r_rem[24:0], 1'b0} : {w_diff[24:0], 1'b0};
        r_q   <= {r_q[23:0], ~w_diff[25]};
        r_cnt <= r_cnt + 5'd1;
      end else if (r_state == PACK) begin
        out  <= w_res;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_floating_div.sv
// tb_floating_div: scoreboard bench for floating_div; results and accept times queued at issue, checked on done.
`timescale 1ns/1ps
module tb_floating_div;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'b0, b = 32'b0;
  logic [31:0] out;
  logic        done, busy;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] sb[$];
  string       tags[$];
  time         tq[$];

  floating_div dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
    .out(out), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", {31'b0, done}, 32'd0);
      else begin
        string t;
        time   t0;
        t  = tags.pop_front();
        t0 = tq.pop_front();
        chk(t, out, sb.pop_front());
        chk({t, "_latency"}, 32'($time - t0), 32'd261);
        chk({t, "_busy_clr"}, {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic issue(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(e);
    tags.push_back(tag);
    tq.push_back($time + 5);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    chk({tag, "_busy_set"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    if (!done) chk("timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    issue(tag, x, y, e);
    wait_done();
  endtask

  initial begin
    #1;
    chk("rst_out", out, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000);
    op("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    op("b2b_one",     32'h3F800000, 32'h3F800000, 32'h3F800000);
    op("two_thirds",  32'h40000000, 32'h40400000, 32'h3F2AAAAB);
    op("ten_by_four", 32'h41200000, 32'h40800000, 32'h40200000);
    op("neg_quarter", 32'h3F800000, 32'hC0800000, 32'hBE800000);
    op("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000);
    op("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000);
    op("inf_inf",     32'h7F800000, 32'h7F800000, 32'h7FC00000);
    op("fin_by_inf",  32'h40000000, 32'h7F800000, 32'h00000000);
    op("nan_in",      32'h7FC12345, 32'h3F800000, 32'h7FC00000);
    op("overflow",    32'h7F7FFFFF, 32'h3F000000, 32'h7F800000);
    op("underflow",   32'h00800000, 32'h40000000, 32'h00000000);
    op("denorm",      32'h80000001, 32'h3F800000, 32'h80000000);
    issue("ignore_base", 32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (4) @(negedge clk);
    a = 32'h3F800000;
    b = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (35) @(negedge clk);
    chk("ignore_queue_empty", 32'(sb.size()), 32'd0);
    op("pre_reset", 32'h3F800000, 32'h3F800000, 32'h3F800000);
    issue("aborted", 32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 32'd0);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    sb.delete();
    tags.delete();
    tq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    chk("post_rst_out", out, 32'd0);
    op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
